// File: rtl/seq_nibble_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_nibble_divider_if
//  Description : Operand-load / readback bus of the sequential nibble divider.
//                i_valid : nibble on i_nib is consumed on a clk edge while high
//                i_sel   : 0 selects quotient, 1 selects status/remainder
//                i_nib   : operand nibble (dividend hi, dividend lo, divisor)
//                o_data  : selected readback byte
//  Revision    : 1.0  initial release
// ============================================================================
interface seq_nibble_divider_if;
   logic       i_valid;
   logic       i_sel;
   logic [3:0] i_nib;
   logic [7:0] o_data;

   modport master (
      output i_valid,
      output i_sel,
      output i_nib,
      input  o_data
   );

   modport slave (
      input  i_valid,
      input  i_sel,
      input  i_nib,
      output o_data
   );
endinterface
`default_nettype wire

// File: rtl/seq_nibble_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_nibble_divider
//  Description : Sequential 8-bit / 4-bit restoring divider. Operands arrive
//                nibble-serially; one quotient bit is produced per clock.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                s_bus  - slave side of seq_nibble_divider_if
//                         (valid / sel / nibble in, readback byte out)
//                Readback: sel=0 -> quotient
//                          sel=1 -> {done, busy, dbz, 1'b0, remainder[3:0]}
//  Revision    : 1.0  initial release
// ============================================================================
module seq_nibble_divider #(
   parameter logic [7:0] DIVZERO_Q = 8'hFF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seq_nibble_divider_if.slave  s_bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LD_LO  = 3'd1,
      S_LD_DIV = 3'd2,
      S_RUN    = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t     r_state, w_state_nxt;
   // Dividend register doubles as the quotient shift register: each RUN
   // step shifts the next dividend bit out of the top and the new quotient
   // bit in at the bottom, so after 8 steps it holds the full quotient.
   logic [7:0] r_dvd,   w_dvd_nxt;
   logic [3:0] r_dvs,   w_dvs_nxt;
   logic [3:0] r_rem,   w_rem_nxt;
   logic [2:0] r_cnt,   w_cnt_nxt;
   logic [7:0] r_q_res, w_q_res_nxt;
   logic [3:0] r_r_res, w_r_res_nxt;
   logic       r_done,  w_done_nxt;
   logic       r_dbz,   w_dbz_nxt;

   // One restoring step. The trial value t is 5 bits (up to 31), but the
   // stored remainder always ends below the divisor, so 4 bits hold it.
   logic [4:0] w_t;
   logic       w_ge;
   logic [3:0] w_diff;
   logic [3:0] w_rem_step;
   logic [7:0] w_dvd_step;
   logic       w_busy;

   assign w_t        = {r_rem, r_dvd[7]};
   assign w_ge       = (w_t >= {1'b0, r_dvs});
   // When t >= dvs the true difference is below 16, so the low nibble
   // difference is exact.
   assign w_diff     = w_t[3:0] - r_dvs;
   // When t < dvs, t < 16 and its top bit is zero.
   assign w_rem_step = w_ge ? w_diff : w_t[3:0];
   assign w_dvd_step = {r_dvd[6:0], w_ge};

   assign w_busy = (r_state == S_LD_LO) || (r_state == S_LD_DIV) ||
                   (r_state == S_RUN);

   assign s_bus.o_data = s_bus.i_sel ? {r_done, w_busy, r_dbz, 1'b0, r_r_res}
                                     : r_q_res;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_dvd   <= 8'h00;
         r_dvs   <= 4'h0;
         r_rem   <= 4'h0;
         r_cnt   <= 3'd0;
         r_q_res <= 8'h00;
         r_r_res <= 4'h0;
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_dvd   <= w_dvd_nxt;
         r_dvs   <= w_dvs_nxt;
         r_rem   <= w_rem_nxt;
         r_cnt   <= w_cnt_nxt;
         r_q_res <= w_q_res_nxt;
         r_r_res <= w_r_res_nxt;
         r_done  <= w_done_nxt;
         r_dbz   <= w_dbz_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_dvd_nxt   = r_dvd;
      w_dvs_nxt   = r_dvs;
      w_rem_nxt   = r_rem;
      w_cnt_nxt   = r_cnt;
      w_q_res_nxt = r_q_res;
      w_r_res_nxt = r_r_res;
      w_done_nxt  = r_done;
      w_dbz_nxt   = r_dbz;

      case (r_state)
         S_IDLE, S_DONE: begin
            // Previous result stays readable until the new one completes.
            if (s_bus.i_valid) begin
               w_dvd_nxt   = {s_bus.i_nib, r_dvd[3:0]};
               w_done_nxt  = 1'b0;
               w_dbz_nxt   = 1'b0;
               w_state_nxt = S_LD_LO;
            end
         end
         S_LD_LO: begin
            if (s_bus.i_valid) begin
               w_dvd_nxt   = {r_dvd[7:4], s_bus.i_nib};
               w_state_nxt = S_LD_DIV;
            end
         end
         S_LD_DIV: begin
            if (s_bus.i_valid) begin
               if (s_bus.i_nib != 4'h0) begin
                  w_dvs_nxt   = s_bus.i_nib;
                  w_rem_nxt   = 4'h0;
                  w_cnt_nxt   = 3'd7;
                  w_state_nxt = S_RUN;
               end else begin
                  // Divide by zero completes immediately without RUN cycles.
                  w_q_res_nxt = DIVZERO_Q;
                  w_r_res_nxt = 4'h0;
                  w_dbz_nxt   = 1'b1;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_RUN: begin
            // valid is deliberately ignored here.
            w_dvd_nxt = w_dvd_step;
            w_rem_nxt = w_rem_step;
            w_cnt_nxt = r_cnt - 3'd1;
            if (r_cnt == 3'd0) begin
               w_q_res_nxt = w_dvd_step;
               w_r_res_nxt = w_rem_step;
               w_done_nxt  = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_nibble_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_nibble_divider
//  Description : Self-checking bench for seq_nibble_divider. Expected results
//                come from plain integer division of the loaded operands.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_nibble_divider;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   bit   clk_en = 1'b0;

   int errors = 0;
   int checks = 0;
   logic [7:0] prev_q = 8'h00;

   seq_nibble_divider_if bus ();

   seq_nibble_divider #(.DIVZERO_Q(8'hFF)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s_bus (bus.slave)
   );

   initial begin
      forever begin
         #5;
         if (clk_en) clk = ~clk;
      end
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic read_out(input logic s, output logic [7:0] v);
      bus.i_sel = s;
      #1;
      v = bus.o_data;
   endtask

   // Called at a falling edge; returns at the following falling edge.
   task automatic send(input logic [3:0] n);
      bus.i_valid = 1'b1;
      bus.i_nib   = n;
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_nib   = 4'($urandom);
   endtask

   // Full load + division with readback checks; reference is a / b.
   task automatic do_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                         input int stall_n, input bit tog);
      logic [7:0] exp_q;
      logic [3:0] exp_r;
      logic [7:0] v;
      if (b == 4'h0) begin
         exp_q = 8'hFF;
         exp_r = 4'h0;
      end else begin
         exp_q = 8'(int'(a) / int'(b));
         exp_r = 4'(int'(a) % int'(b));
      end

      send(a[7:4]);
      read_out(1'b1, v);
      check({tag, "_ld_busy"}, v & 8'hE0, 8'h40);
      read_out(1'b0, v);
      check({tag, "_ld_qhold"}, v, prev_q);
      repeat (stall_n) @(negedge clk);
      send(a[3:0]);
      repeat (stall_n) @(negedge clk);
      send(b);

      if (b != 4'h0) begin
         for (int i = 0; i < 8; i++) begin
            read_out(1'b1, v);
            check($sformatf("%s_run%0d_busy", tag, i), v & 8'hE0, 8'h40);
            read_out(1'b0, v);
            check($sformatf("%s_run%0d_qhold", tag, i), v, prev_q);
            bus.i_valid = (tog && i < 7) ? 1'($urandom) : 1'b0;
            bus.i_nib   = 4'h3;
            @(negedge clk);
         end
         bus.i_valid = 1'b0;
      end

      read_out(1'b0, v);
      check({tag, "_q"}, v, exp_q);
      read_out(1'b1, v);
      check({tag, "_st"}, v, {1'b1, 1'b0, (b == 4'h0), 1'b0, exp_r});
      prev_q = exp_q;
   endtask

   initial begin
      logic [7:0] v;
      logic [7:0] ra;
      logic [3:0] rb;

      bus.i_valid = 1'b0;
      bus.i_sel   = 1'b0;
      bus.i_nib   = 4'h0;

      // Reset with the clock stopped.
      #2 rst_n = 1'b0;
      #3;
      read_out(1'b0, v);
      check("rst_q", v, 8'h00);
      read_out(1'b1, v);
      check("rst_st", v, 8'h00);
      #4 rst_n = 1'b1;
      clk_en = 1'b1;
      repeat (2) @(negedge clk);
      read_out(1'b1, v);
      check("idle_st", v, 8'h00);

      do_div("d225_15", 8'd225, 4'd15, 0, 1'b0);
      do_div("d200_7", 8'd200, 4'd7, 0, 1'b0);
      do_div("d255_1", 8'd255, 4'd1, 0, 1'b0);
      do_div("d2A_0", 8'h2A, 4'd0, 0, 1'b0);
      do_div("d200_7s", 8'd200, 4'd7, 3, 1'b1);

      // Abort mid-RUN: previous result must be lost.
      send(4'hE);
      send(4'h1);
      send(4'hF);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      read_out(1'b0, v);
      check("abort_q", v, 8'h00);
      read_out(1'b1, v);
      check("abort_st", v, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      prev_q = 8'h00;
      @(negedge clk);
      do_div("d21_7", 8'd21, 4'd7, 0, 1'b0);

      for (int k = 0; k < 8; k++) begin
         ra = 8'($urandom);
         rb = (k == 3) ? 4'h0 : 4'($urandom);
         do_div($sformatf("rnd%0d", k), ra, rb, int'($urandom_range(0, 2)), 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
